parallel_to_serial: RTL and testbench

- Downstream stage of mon_exp. Captures the N-bit result `ans` when mon_exp's `stop` rises.
- Streams the result out as bytes to the UART transmitter over a valid/ready handshake.
- Byte order is MSB-first, the same order serial_to_parallel receives operands, so the host reads the result in its own byte order.
- Completes the RSA datapath: UART rx -> serial_to_parallel -> mon_exp -> parallel_to_serial -> UART tx.

---
 rtl/rsa_pkg.sv | 9 +
 rtl/edge_detect.sv | 24 ++
 rtl/parallel_to_serial.sv | 109 ++++++++++
 tb/tb_parallel_to_serial.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared constants for the RSA datapath: byte width and the
// two-state transfer FSM encoding used by the serialiser.
package rsa_pkg;

  localparam int   BYTE_W  = 8;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector; the delayed register's reset value is
// configurable so a level already high at reset release is not an edge.
module edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= RESET_VAL;
    else      prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/parallel_to_serial.sv
// Captures the N-bit mon_exp result on a start rising edge and streams it
// MSB-first as bytes over a valid/ready handshake to the UART transmitter.
module parallel_to_serial
  import rsa_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] din,
  input  logic         tx_ready,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [CW-1:0] CNT_INIT = CW'(N / BYTE_W);

  logic           start_edge;
  logic           state_q,    state_d;
  logic [N-1:0]   shreg_q,    shreg_d;
  logic [CW-1:0]  cnt_q,      cnt_d;
  logic [7:0]     tx_byte_q,  tx_byte_d;
  logic           tx_valid_q, tx_valid_d;
  logic           busy_q,     busy_d;
  logic           done_q,     done_d;
  logic [N-1:0]   shifted;

  // Reset value 1 keeps a start level held across reset release from firing.
  edge_detect #(.RESET_VAL(1'b1)) u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (start),
    .rise (start_edge)
  );

  assign shifted = shreg_q << BYTE_W;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        tx_byte_d  = '0;
        if (start_edge) begin
          shreg_d    = din;
          cnt_d      = CNT_INIT;
          state_d    = ST_SEND;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          tx_byte_d  = din[N-1 -: BYTE_W];
        end
      end
      default: begin
        // The next byte is registered from the shifted value so there is no bubble.
        if (tx_valid_q && tx_ready) begin
          if (cnt_q > CW'(1)) begin
            shreg_d   = shifted;
            cnt_d     = cnt_q - CW'(1);
            tx_byte_d = shifted[N-1 -: BYTE_W];
          end else begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            tx_byte_d  = '0;
            done_d     = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial: a 16-bit and a 32-bit instance
// driven from one process, with expected bytes queued and popped on acceptance.
module tb_parallel_to_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start32;
  logic [15:0] din16;
  logic [31:0] din32;
  logic        txReady16, txReady32;
  logic [7:0]  txByte16, txByte32;
  logic        txValid16, txValid32;
  logic        busy16, busy32;
  logic        done16, done32;

  int checks = 0;
  int errors = 0;

  logic [7:0] q16[$];
  logic [7:0] q32[$];

  int validCycles16, stallCycles16, busyCycles16, doneCount16;
  int validCycles32, stallCycles32, busyCycles32, doneCount32;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
    logic [7:0]  readyPat;
  } vec_t;

  vec_t vecs[5];

  parallel_to_serial #(.N(16), .CW(4)) dut16 (
    .clk      (clk),
    .rst      (rst),
    .start    (start16),
    .din      (din16),
    .tx_ready (txReady16),
    .tx_byte  (txByte16),
    .tx_valid (txValid16),
    .busy     (busy16),
    .done     (done16)
  );

  parallel_to_serial #(.N(32), .CW(4)) dut32 (
    .clk      (clk),
    .rst      (rst),
    .start    (start32),
    .din      (din32),
    .tx_ready (txReady32),
    .tx_byte  (txByte32),
    .tx_valid (txValid32),
    .busy     (busy32),
    .done     (done32)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearCounters();
    validCycles16 = 0; stallCycles16 = 0; busyCycles16 = 0; doneCount16 = 0;
    validCycles32 = 0; stallCycles32 = 0; busyCycles32 = 0; doneCount32 = 0;
  endtask

  // Samples both instances mid-cycle, comparing offered bytes with the scoreboard.
  task automatic monitor();
    if (rst && txValid16) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_byte16 got %02h expected none at %0t", txByte16, $time);
      end else begin
        checkEq("byte16", {24'd0, txByte16}, {24'd0, q16[0]});
        if (txReady16) void'(q16.pop_front());
      end
    end
    if (rst && txValid32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_byte32 got %02h expected none at %0t", txByte32, $time);
      end else begin
        checkEq("byte32", {24'd0, txByte32}, {24'd0, q32[0]});
        if (txReady32) void'(q32.pop_front());
      end
    end
    if (txValid16) validCycles16++;
    if (txValid16 && !txReady16) stallCycles16++;
    if (busy16) busyCycles16++;
    if (done16) doneCount16++;
    if (txValid32) validCycles32++;
    if (txValid32 && !txReady32) stallCycles32++;
    if (busy32) busyCycles32++;
    if (done32) doneCount32++;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] din, input logic [7:0] exp0,
                               input logic [7:0] exp1, input logic [7:0] pat);
    clearCounters();
    q16.push_back(exp0);
    q16.push_back(exp1);
    din16   = din;
    start16 = 1'b1;
    for (int k = 0; k < 40 && doneCount16 == 0; k++) begin
      txReady16 = pat[k % 8];
      cycle();
      start16 = 1'b0;
    end
    txReady16 = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic checkOutput(input string name, input int expDone);
    checkEq({name, "_done_count"}, doneCount16, expDone);
    checkEq({name, "_queue_left"}, q16.size(), 0);
    checkEq({name, "_valid_cycles"}, validCycles16, 2 * expDone + stallCycles16);
    checkEq({name, "_busy_cycles"}, busyCycles16, validCycles16);
  endtask

  initial begin
    vecs[0] = '{din: 16'h0123, exp0: 8'h01, exp1: 8'h23, readyPat: 8'hFF};
    vecs[1] = '{din: 16'hABCD, exp0: 8'hAB, exp1: 8'hCD, readyPat: 8'b1111_0001};
    vecs[2] = '{din: 16'h00FF, exp0: 8'h00, exp1: 8'hFF, readyPat: 8'hAA};
    vecs[3] = '{din: 16'h8001, exp0: 8'h80, exp1: 8'h01, readyPat: 8'h55};
    vecs[4] = '{din: 16'hFFFF, exp0: 8'hFF, exp1: 8'hFF, readyPat: 8'hC3};

    start16 = 1'b0; start32 = 1'b0;
    din16 = '0; din32 = '0;
    txReady16 = 1'b1; txReady32 = 1'b1;
    clearCounters();

    rst = 1'b1;
    #3 rst = 1'b0;
    #10;
    checkEq("reset_valid16", {31'd0, txValid16}, 32'd0);
    checkEq("reset_busy16",  {31'd0, busy16},    32'd0);
    checkEq("reset_done16",  {31'd0, done16},    32'd0);
    checkEq("reset_byte16",  {24'd0, txByte16},  32'd0);
    checkEq("reset_valid32", {31'd0, txValid32}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) cycle();

    // Table-driven single transfers, including no-backpressure 0123 case
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].din, vecs[i].exp0, vecs[i].exp1, vecs[i].readyPat);
      checkOutput($sformatf("vec%0d", i), 1);
    end

    // Backpressure: first byte held three cycles
    clearCounters();
    q16.push_back(8'hAB); q16.push_back(8'hCD);
    din16 = 16'hABCD; start16 = 1'b1; txReady16 = 1'b0;
    cycle();
    start16 = 1'b0;
    repeat (3) cycle();
    checkEq("bp_stall_cycles", stallCycles16, 3);
    txReady16 = 1'b1;
    repeat (4) cycle();
    checkOutput("backpressure", 1);
    checkEq("bp_valid_total", validCycles16, 5);

    // Start held as a level: one transfer, then a new edge gives another
    clearCounters();
    q16.push_back(8'h00); q16.push_back(8'hFF);
    din16 = 16'h00FF; start16 = 1'b1; txReady16 = 1'b1;
    repeat (10) cycle();
    start16 = 1'b0;
    cycle();
    checkEq("level_done_once", doneCount16, 1);
    q16.push_back(8'h00); q16.push_back(8'hFF);
    start16 = 1'b1;
    repeat (4) cycle();
    start16 = 1'b0;
    repeat (2) cycle();
    checkOutput("level_second", 2);

    // Start edge during SEND with a new din is ignored
    clearCounters();
    q16.push_back(8'h12); q16.push_back(8'h34);
    din16 = 16'h1234; start16 = 1'b1; txReady16 = 1'b0;
    cycle();
    start16 = 1'b0;
    cycle();
    din16 = 16'h5555; start16 = 1'b1;
    repeat (2) cycle();
    start16 = 1'b0; txReady16 = 1'b1;
    repeat (5) cycle();
    checkOutput("ignore_start", 1);

    // Start edge coincident with the done pulse begins a new transfer
    clearCounters();
    q16.push_back(8'h01); q16.push_back(8'h23);
    q16.push_back(8'h45); q16.push_back(8'h67);
    din16 = 16'h0123; start16 = 1'b1; txReady16 = 1'b1;
    cycle();
    start16 = 1'b0;
    repeat (2) cycle();
    checkEq("b2b_done_visible", {31'd0, done16}, 32'd1);
    din16 = 16'h4567; start16 = 1'b1;
    cycle();
    start16 = 1'b0;
    repeat (4) cycle();
    checkOutput("back_to_back", 2);

    // Asynchronous reset mid-transfer with start held high across release
    clearCounters();
    din16 = 16'hBEEF; start16 = 1'b1; txReady16 = 1'b0;
    cycle();
    checkEq("abort_pre_valid", {31'd0, txValid16}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkEq("abort_valid", {31'd0, txValid16}, 32'd0);
    checkEq("abort_busy",  {31'd0, busy16},    32'd0);
    checkEq("abort_byte",  {24'd0, txByte16},  32'd0);
    cycle();
    #3 rst = 1'b1;
    clearCounters();
    txReady16 = 1'b1;
    repeat (5) cycle();
    checkEq("abort_no_done",    doneCount16,   0);
    checkEq("abort_no_restart", validCycles16, 0);
    start16 = 1'b0;
    cycle();

    // 32-bit instance with alternating ready
    clearCounters();
    q32.push_back(8'hDE); q32.push_back(8'hAD);
    q32.push_back(8'hBE); q32.push_back(8'hEF);
    din32 = 32'hDEADBEEF; start32 = 1'b1;
    for (int k = 0; k < 40 && doneCount32 == 0; k++) begin
      txReady32 = (k % 2 == 0);
      cycle();
      start32 = 1'b0;
    end
    txReady32 = 1'b1;
    repeat (3) cycle();
    checkEq("w32_done_count", doneCount32, 1);
    checkEq("w32_queue_left", q32.size(), 0);
    checkEq("w32_valid_cycles", validCycles32, 4 + stallCycles32);
    checkEq("w32_busy_cycles", busyCycles32, validCycles32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
